// File: rtl/led_fader.sv
// LED fader: ramps a PWM duty cycle toward the requested on/off level.
// A reversal mid-ramp turns around from the current duty without a jump.
//
// state | meaning
// LOW   | duty 0, idle, LED off
// RISE  | duty stepping up once every STEP_DIV cycles
// HIGH  | duty MAX, idle, LED fully on
// FALL  | duty stepping down once every STEP_DIV cycles
module led_fader #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 48828
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                led_i,
   output logic                led_o,
   output logic                busy_o,
   output logic [PWM_BITS-1:0] duty_o
);

   localparam int SW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] D_MAX  = '1;
   localparam logic [SW-1:0]       S_LAST = SW'(STEP_DIV - 1);

   typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

   state_t              state, state_nxt;
   logic                t;
   logic [PWM_BITS-1:0] d, d_nxt;
   logic [PWM_BITS-1:0] p;
   logic [SW-1:0]       s, s_nxt;
   logic                step;
   logic [SW-1:0]       s_inc;
   logic [PWM_BITS-1:0] d_up, d_dn;

   assign step  = (s == S_LAST);
   assign s_inc = step ? '0 : s + 1'b1;
   assign d_up  = d + 1'b1;
   assign d_dn  = d - 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         t     <= 1'b0;
         state <= LOW;
         d     <= '0;
         p     <= '0;
         s     <= '0;
         led_o <= 1'b0;
      end else begin
         t     <= led_i;
         state <= state_nxt;
         d     <= d_nxt;
         p     <= p + 1'b1;
         s     <= s_nxt;
         led_o <= (d == D_MAX) || (p < d);
      end
   end

   // A reversal takes priority over a pending step, so D is untouched that cycle.
   always_comb begin
      state_nxt = state;
      d_nxt     = d;
      s_nxt     = '0;
      unique case (state)
         LOW: begin
            if (t) state_nxt = RISE;
         end
         RISE: begin
            if (!t) begin
               state_nxt = FALL;
            end else if (d == D_MAX) begin
               state_nxt = HIGH;
            end else begin
               s_nxt = s_inc;
               if (step) begin
                  d_nxt = d_up;
                  if (d_up == D_MAX) state_nxt = HIGH;
               end
            end
         end
         HIGH: begin
            if (!t) state_nxt = FALL;
         end
         FALL: begin
            if (t) begin
               state_nxt = RISE;
            end else if (d == '0) begin
               state_nxt = LOW;
            end else begin
               s_nxt = s_inc;
               if (step) begin
                  d_nxt = d_dn;
                  if (d_dn == '0) state_nxt = LOW;
               end
            end
         end
         default: state_nxt = LOW;
      endcase
   end

   assign busy_o = (state == RISE) || (state == FALL);
   assign duty_o = d;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: PWM_BITS=4 with STEP_DIV=3 for sequencing,
// and a second instance with STEP_DIV=1000 for the PWM waveform shape.
module tb_led_fader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       led = 1'b0;
   logic       led_out, busy;
   logic [3:0] duty;

   logic       rst2 = 1'b1;
   logic       led2 = 1'b0;
   logic       led_out2, busy2;
   logic [3:0] duty2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_fader #(.PWM_BITS(4), .STEP_DIV(3)) dut (
      .clk_i(clk), .rst_i(rst), .led_i(led),
      .led_o(led_out), .busy_o(busy), .duty_o(duty)
   );

   led_fader #(.PWM_BITS(4), .STEP_DIV(1000)) dut_pwm (
      .clk_i(clk), .rst_i(rst2), .led_i(led2),
      .led_o(led_out2), .busy_o(busy2), .duty_o(duty2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns dut to LOW with T=0 and led_i low.
   task automatic do_reset();
      rst = 1'b1;
      led = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      led = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (led_out !== 1'b0 || busy !== 1'b0 || duty !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got led=%b busy=%b duty=%0d want 0 0 0",
                     i, led_out, busy, duty);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_e0: got busy=%b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_e1: got busy=%b want 1", busy);
      end
   endtask

   task automatic test_full_rise();
      logic [3:0] exp_d;
      do_reset();
      led = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rise_e0_busy: got %b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || duty !== 4'd0) begin
         errors++;
         $display("FAIL rise_e1: got busy=%b duty=%0d want 1 0", busy, duty);
      end
      for (int k = 1; k <= 45; k++) begin
         tick();
         exp_d = 4'(k / 3);
         checks++;
         if (duty !== exp_d) begin
            errors++;
            $display("FAIL rise_duty[%0d]: got %0d want %0d", k, duty, exp_d);
         end
         if (k >= 44) begin
            checks++;
            if (busy !== (k == 44)) begin
               errors++;
               $display("FAIL rise_busy[%0d]: got %b want %b", k, busy, (k == 44));
            end
         end
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (led_out !== 1'b1) begin
            errors++;
            $display("FAIL high_led[%0d]: got %b want 1", i, led_out);
         end
         tick();
      end
   endtask

   task automatic test_full_fall();
      logic [3:0] exp_d;
      led = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || duty !== 4'd15) begin
         errors++;
         $display("FAIL fall_e0: got busy=%b duty=%0d want 0 15", busy, duty);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || duty !== 4'd15) begin
         errors++;
         $display("FAIL fall_e1: got busy=%b duty=%0d want 1 15", busy, duty);
      end
      for (int k = 1; k <= 45; k++) begin
         tick();
         exp_d = 4'(15 - k / 3);
         checks++;
         if (duty !== exp_d) begin
            errors++;
            $display("FAIL fall_duty[%0d]: got %0d want %0d", k, duty, exp_d);
         end
         if (k >= 44) begin
            checks++;
            if (busy !== (k == 44)) begin
               errors++;
               $display("FAIL fall_busy[%0d]: got %b want %b", k, busy, (k == 44));
            end
         end
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (led_out !== 1'b0) begin
            errors++;
            $display("FAIL low_led[%0d]: got %b want 0", i, led_out);
         end
         tick();
      end
   endtask

   task automatic test_pwm_shape();
      int   n;
      int   highs;
      logic done;
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      led2 = 1'b1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 10000) begin
         tick();
         n++;
         if (duty2 == 4'd5) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL pwm_ramp_timeout: got duty=%0d after %0d cycles want 5", duty2, n);
      end
      tick();
      highs = 0;
      for (int i = 0; i < 16; i++) begin
         if (led_out2 === 1'b1) highs++;
         tick();
      end
      checks++;
      if (highs != 5) begin
         errors++;
         $display("FAIL pwm_high_count: got %0d want 5", highs);
      end
      checks++;
      if (duty2 !== 4'd5 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL pwm_duty_hold: got duty=%0d busy=%b want 5 1", duty2, busy2);
      end
   endtask

   task automatic test_mid_reversal();
      logic [3:0] exp_d;
      do_reset();
      led = 1'b1;
      tick();
      tick();
      for (int k = 1; k <= 21; k++) tick();
      checks++;
      if (duty !== 4'd7) begin
         errors++;
         $display("FAIL rev_start_duty: got %0d want 7", duty);
      end
      led = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (duty !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rev_hold[%0d]: got duty=%0d busy=%b want 7 1", i, duty, busy);
         end
      end
      for (int k = 1; k <= 21; k++) begin
         tick();
         exp_d = 4'(7 - k / 3);
         checks++;
         if (duty !== exp_d) begin
            errors++;
            $display("FAIL rev_duty[%0d]: got %0d want %0d", k, duty, exp_d);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rev_end_busy: got %b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || duty !== 4'd0) begin
         errors++;
         $display("FAIL rev_low: got busy=%b duty=%0d want 0 0", busy, duty);
      end
   endtask

   // Reversal lands on the very edge a step would fire: the step is dropped.
   task automatic test_step_reversal();
      logic [3:0] exp_d [1:5];
      logic       exp_b [1:5];
      exp_d = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
      exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      led = 1'b1;
      tick();
      tick();
      for (int k = 1; k <= 4; k++) tick();
      led = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (duty !== exp_d[k] || busy !== exp_b[k]) begin
            errors++;
            $display("FAIL step_rev[%0d]: got duty=%0d busy=%b want %0d %b",
                     k, duty, busy, exp_d[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_glitch();
      logic exp_b [0:5];
      exp_b = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      led = 1'b1;
      tick();
      led = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (busy !== exp_b[i] || duty !== 4'd0 || led_out !== 1'b0) begin
            errors++;
            $display("FAIL glitch[%0d]: got busy=%b duty=%0d led=%b want %b 0 0",
                     i, busy, duty, led_out, exp_b[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_ramp();
      do_reset();
      led = 1'b1;
      tick();
      tick();
      for (int k = 1; k <= 27; k++) tick();
      checks++;
      if (duty !== 4'd9 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got duty=%0d busy=%b want 9 1", duty, busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (duty !== 4'd0 || busy !== 1'b0 || led_out !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_edge: got duty=%0d busy=%b led=%b want 0 0 0",
                  duty, busy, led_out);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_e0: got busy=%b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || duty !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_e1: got busy=%b duty=%0d want 1 0", busy, duty);
      end
      for (int k = 1; k <= 3; k++) tick();
      checks++;
      if (duty !== 4'd1) begin
         errors++;
         $display("FAIL rstmid_restart: got duty=%0d want 1", duty);
      end
   endtask

   initial begin
      test_reset();
      test_full_rise();
      test_full_fall();
      test_pwm_shape();
      test_mid_reversal();
      test_step_reversal();
      test_glitch();
      test_reset_mid_ramp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
